// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART serial transmitter with a valid/ready request interface.
// Each frame is: start bit, NBits data bits (LSB first), an optional
// even/odd parity bit, then one or two stop bits. Every bit lasts OVS Tick
// pulses, and Tick is a one-cycle enable at baud*OVS. Frames can run
// back-to-back with a single idle Clk between them.
//
// Ports
//   Clk        : clock, all state changes on its rising edge
//   Rst_n      : asynchronous active-low reset
//   Tick       : oversample enable pulse (baud*OVS)
//   TxValid    : frame request; TxData and the config inputs are valid while high
//   TxReady    : high while the transmitter is idle and can accept a frame
//   TxData     : data word, sent LSB first
//   NBits      : data bits in this frame (clamped to 5..DATA_W)
//   ParityMode : 00 none, 01 even, 10 odd, 11 none
//   TwoStop    : 1 selects two stop bits
//   Tx         : serial line, idles high
//   TxBusy     : high from accept until the end of the last stop bit
//   TxDone     : one-Clk pulse when a frame completes
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int CNT_W  = $clog2(OVS)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tick,
    input  logic              TxValid,
    output logic              TxReady,
    input  logic [DATA_W-1:0] TxData,
    input  logic [3:0]        NBits,
    input  logic [1:0]        ParityMode,
    input  logic              TwoStop,
    output logic              Tx,
    output logic              TxBusy,
    output logic              TxDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  tickCnt_q;
    logic [4:0]        bitCnt_q;
    logic [4:0]        nBits_q;
    logic [DATA_W-1:0] shreg_q;
    logic              parityBit_q;
    logic              parityEn_q;
    logic              twoStop_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic [4:0]        nBits_d;
    logic              parityBit_d;
    logic              parityEn_d;
    logic              bitEnd;

    // Word length clamped to the supported range, then the parity bit over
    // exactly those bits. Both are captured in the frame registers at accept,
    // so later changes on the inputs cannot disturb a frame in progress.
    always_comb begin
        if (NBits < 4'd5) begin
            nBits_d = 5'd5;
        end else if ({1'b0, NBits} > 5'(DATA_W)) begin
            nBits_d = 5'(DATA_W);
        end else begin
            nBits_d = {1'b0, NBits};
        end

        parityBit_d = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(nBits_d)) begin
                parityBit_d = parityBit_d ^ TxData[i];
            end
        end
        if (ParityMode == 2'b10) begin
            parityBit_d = ~parityBit_d;
        end

        parityEn_d = (ParityMode == 2'b01) || (ParityMode == 2'b10);
    end

    // The OVS-th Tick of the current bit; the FSM advances on this edge.
    assign bitEnd = Tick && (tickCnt_q == CNT_W'(OVS - 1));

    // Frame sequencer. Tx, TxBusy and TxDone are registered and only change
    // on an accept edge or a bit-end edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitCnt_q    <= '0;
            nBits_q     <= '0;
            shreg_q     <= '0;
            parityBit_q <= 1'b0;
            parityEn_q  <= 1'b0;
            twoStop_q   <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Ticks count only inside a frame; the accept edge resets the count,
            // so a Tick coincident with accept is not part of the start bit.
            if (state_q != IDLE && Tick) begin
                tickCnt_q <= bitEnd ? '0 : tickCnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (TxValid) begin
                        shreg_q     <= TxData;
                        nBits_q     <= nBits_d;
                        parityBit_q <= parityBit_d;
                        parityEn_q  <= parityEn_d;
                        twoStop_q   <= TwoStop;
                        tickCnt_q   <= '0;
                        bitCnt_q    <= '0;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end

                START: begin
                    if (bitEnd) begin
                        tx_q     <= shreg_q[0];
                        shreg_q  <= shreg_q >> 1;
                        bitCnt_q <= '0;
                        state_q  <= DATA;
                    end
                end

                DATA: begin
                    if (bitEnd) begin
                        if (bitCnt_q == nBits_q - 5'd1) begin
                            if (parityEn_q) begin
                                tx_q    <= parityBit_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP1;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + 5'd1;
                            tx_q     <= shreg_q[0];
                            shreg_q  <= shreg_q >> 1;
                        end
                    end
                end

                PARITY: begin
                    if (bitEnd) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP1;
                    end
                end

                STOP1: begin
                    if (bitEnd) begin
                        if (twoStop_q) begin
                            state_q <= STOP2;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                STOP2: begin
                    if (bitEnd) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TxReady = (state_q == IDLE);
    assign Tx      = tx_q;
    assign TxBusy  = busy_q;
    assign TxDone  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame with OVS=16 and a Tick every 4 Clk.
// Expected line levels for each frame are built from a small reference model
// and queued when the frame is requested; they are popped and compared as the
// DUT walks through each bit (at the start of the bit and just before its
// final Tick, which also pins the bit length to exactly 16 Ticks).
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;

    logic              Clk;
    logic              Rst_n;
    logic              Tick;
    logic              TxValid;
    logic              TxReady;
    logic [DATA_W-1:0] TxData;
    logic [3:0]        NBits;
    logic [1:0]        ParityMode;
    logic              TwoStop;
    logic              Tx;
    logic              TxBusy;
    logic              TxDone;

    int   errors;
    int   checks;
    bit   expQ[$];
    int   nTot;

    uart_tx_frame #(
        .DATA_W(DATA_W),
        .OVS   (OVS)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Tick      (Tick),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .TxData    (TxData),
        .NBits     (NBits),
        .ParityMode(ParityMode),
        .TwoStop   (TwoStop),
        .Tx        (Tx),
        .TxBusy    (TxBusy),
        .TxDone    (TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Tick pulse one Clk out of every four, changed on the falling edge.
    initial begin
        int div;
        div  = 0;
        Tick = 1'b0;
        forever begin
            @(negedge Clk);
            div  = (div + 1) % 4;
            Tick = (div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until n Ticks have been seen on rising edges, then settle 1 ns.
    task automatic waitTicks(input int n);
        int got;
        int guard;
        got   = 0;
        guard = 0;
        while (got < n && guard < n * 20 + 20) begin
            @(posedge Clk);
            guard++;
            if (Tick) got++;
        end
        #1;
        if (got < n) check("tickTimeout", 32'(got), 32'(n));
    endtask

    // Reference model: queue the line level of every bit of a frame.
    task automatic pushFrame(input logic [DATA_W-1:0] data, input logic [3:0] nb,
                             input logic [1:0] pm, input logic ts, output int total);
        int  n;
        bit  par;
        n   = (nb < 5) ? 5 : ((nb > DATA_W) ? DATA_W : int'(nb));
        par = 1'b0;
        expQ.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(data[i]);
            par = par ^ data[i];
        end
        total = 1 + n + 1;
        if (pm == 2'b01 || pm == 2'b10) begin
            expQ.push_back((pm == 2'b10) ? ~par : par);
            total++;
        end
        expQ.push_back(1'b1);
        if (ts) begin
            expQ.push_back(1'b1);
            total++;
        end
    endtask

    // Request a frame and wait for the accept edge. dataAfter is applied to
    // TxData right after accept; expGap checks acceptance one Clk after entry.
    task automatic acceptFrame(input logic [DATA_W-1:0] data, input logic [3:0] nb,
                               input logic [1:0] pm, input logic ts,
                               input logic [DATA_W-1:0] dataAfter, input bit dropValid,
                               input bit expGap, output int total);
        bit rdy;
        bit vld;
        int cycles;
        pushFrame(data, nb, pm, ts, total);
        TxData     = data;
        NBits      = nb;
        ParityMode = pm;
        TwoStop    = ts;
        TxValid    = 1'b1;
        cycles     = 0;
        do begin
            rdy = TxReady;
            vld = TxValid;
            @(posedge Clk);
            cycles++;
        end while (!(rdy && vld) && cycles < 200);
        #1;
        if (expGap) check("acceptGap", 32'(cycles), 32'd1);
        check("acceptBusy", 32'(TxBusy), 32'd1);
        check("acceptReady", 32'(TxReady), 32'd0);
        TxData = dataAfter;
        if (dropValid) TxValid = 1'b0;
    endtask

    // Pop and compare each queued bit as the DUT produces it.
    task automatic monitorFrame(input int total);
        bit exp;
        for (int b = 0; b < total; b++) begin
            exp = (expQ.size() > 0) ? expQ.pop_front() : 1'bx;
            check("bitStart", 32'(Tx), 32'(exp));
            waitTicks(OVS - 1);
            check("bitHold", 32'(Tx), 32'(exp));
            if (b == total - 1) begin
                check("notDoneYet", 32'(TxDone), 32'd0);
                check("readyLowInFrame", 32'(TxReady), 32'd0);
            end
            waitTicks(1);
        end
        check("doneTxDone", 32'(TxDone), 32'd1);
        check("doneBusy", 32'(TxBusy), 32'd0);
        check("doneReady", 32'(TxReady), 32'd1);
        check("doneTxIdle", 32'(Tx), 32'd1);
    endtask

    // Directed sequence: reset, then each frame shape in turn.
    initial begin
        errors     = 0;
        checks     = 0;
        Rst_n      = 1'b0;
        TxValid    = 1'b0;
        TxData     = '0;
        NBits      = 4'd8;
        ParityMode = 2'b00;
        TwoStop    = 1'b0;
        #12;
        check("rstTx", 32'(Tx), 32'd1);
        check("rstReady", 32'(TxReady), 32'd1);
        check("rstBusy", 32'(TxBusy), 32'd0);
        check("rstDone", 32'(TxDone), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("idleTx", 32'(Tx), 32'd1);

        $display("[TB] 0x55, 8 bits, no parity, 1 stop");
        acceptFrame(8'h55, 4'd8, 2'b00, 1'b0, 8'h55, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);

        $display("[TB] 0x07 even, then odd parity");
        acceptFrame(8'h07, 4'd8, 2'b01, 1'b0, 8'h07, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);
        acceptFrame(8'h07, 4'd8, 2'b10, 1'b0, 8'h07, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);

        $display("[TB] 0x1F, NBits=3 clamped to 5, odd, two stop");
        acceptFrame(8'h1F, 4'd3, 2'b10, 1'b1, 8'h1F, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);

        $display("[TB] NBits=15 clamped to 8, even, mode 11 next");
        acceptFrame(8'hB2, 4'd15, 2'b01, 1'b0, 8'hB2, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);
        acceptFrame(8'h6D, 4'd6, 2'b11, 1'b0, 8'h6D, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);

        $display("[TB] back-to-back 0xA5 then 0x3C");
        acceptFrame(8'hA5, 4'd8, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, nTot);
        monitorFrame(nTot);
        acceptFrame(8'h3C, 4'd8, 2'b00, 1'b0, 8'h3C, 1'b1, 1'b1, nTot);
        monitorFrame(nTot);

        $display("[TB] reset during 4th data bit");
        acceptFrame(8'h00, 4'd8, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, nTot);
        waitTicks(72);
        check("preRstTxLow", 32'(Tx), 32'd0);
        Rst_n = 1'b0;
        #1;
        check("midRstTx", 32'(Tx), 32'd1);
        check("midRstBusy", 32'(TxBusy), 32'd0);
        check("midRstReady", 32'(TxReady), 32'd1);
        expQ.delete();
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        acceptFrame(8'h96, 4'd7, 2'b01, 1'b1, 8'h96, 1'b1, 1'b0, nTot);
        monitorFrame(nTot);

        $display("[TB] TxData and config changed mid-frame");
        acceptFrame(8'hC3, 4'd8, 2'b10, 1'b0, 8'h18, 1'b1, 1'b0, nTot);
        NBits      = 4'd5;
        ParityMode = 2'b00;
        TwoStop    = 1'b1;
        monitorFrame(nTot);

        repeat (5) @(negedge Clk);
        check("finalIdle", 32'(Tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
